fwd_hazard_unit: RTL and testbench

Parametrised operand forwarding and load-use hazard unit for the lc3b pipeline. It generalises two-operand, two-stage forwarding to NUM_SRC source operands and NUM_FWD forwarding stages, with youngest-stage priority. It adds not-ready detection (load data still in flight), a stall/bubble request, a stall-tracking FSM with a timeout flag, and saturating hazard counters. It sits beside the DE/EX register, drives the EX operand muxes, and drives the pipeline stall/bubble controls.

---
 rtl/fwd_hazard_unit_pkg.sv | 13 +
 rtl/fwd_hazard_unit_if.sv | 38 +++
 rtl/fwd_match_pri.sv | 41 ++++
 rtl/fwd_hazard_unit.sv | 93 +++++++++
 tb/tb_fwd_hazard_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the lc3b forwarding / load-use hazard unit.
package fwd_hazard_unit_pkg;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic {FH_RUN, FH_STALL} fwd_hazard_state_t;

    // Width of a forwarding select: 0 = regfile, k = stage k-1.
    function automatic int unsigned fwd_sel_w(int unsigned num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// DE/EX-side bundle between the pipeline (master) and the hazard unit (slave).
interface fwd_hazard_unit_if #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned CNT_W   = 16
);
    import fwd_hazard_unit_pkg::*;

    localparam int unsigned FWD_SEL_W = fwd_sel_w(NUM_FWD);

    logic                                de_ex_valid;
    lc3b_reg [NUM_SRC-1:0]               de_ex_src;
    logic    [NUM_SRC-1:0]               de_ex_src_used;
    logic    [NUM_FWD-1:0]               stg_valid;
    logic    [NUM_FWD-1:0]               stg_load_regfile;
    lc3b_reg [NUM_FWD-1:0]               stg_dr;
    logic    [NUM_FWD-1:0]               stg_ready;
    logic                                freeze;
    logic    [NUM_SRC-1:0][FWD_SEL_W-1:0] fwd_sel;
    logic                                stall;
    logic                                bubble;
    logic                                stall_timeout;
    logic    [CNT_W-1:0]                 hazard_cnt;
    logic    [CNT_W-1:0]                 stall_cyc_cnt;

    modport master (
        output de_ex_valid, de_ex_src, de_ex_src_used, stg_valid, stg_load_regfile, stg_dr,
               stg_ready, freeze,
        input  fwd_sel, stall, bubble, stall_timeout, hazard_cnt, stall_cyc_cnt
    );

    modport slave (
        input  de_ex_valid, de_ex_src, de_ex_src_used, stg_valid, stg_load_regfile, stg_dr,
               stg_ready, freeze,
        output fwd_sel, stall, bubble, stall_timeout, hazard_cnt, stall_cyc_cnt
    );

endinterface

// File: rtl/fwd_match_pri.sv
// One source operand checked against all forwarding stages; youngest match wins.
module fwd_match_pri
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned NUM_FWD = 2
) (
    input  logic                                 de_ex_valid,
    input  lc3b_reg                              src,
    input  logic                                 src_used,
    input  logic    [NUM_FWD-1:0]                stg_valid,
    input  logic    [NUM_FWD-1:0]                stg_load_regfile,
    input  lc3b_reg [NUM_FWD-1:0]                stg_dr,
    input  logic    [NUM_FWD-1:0]                stg_ready,
    output logic    [fwd_sel_w(NUM_FWD)-1:0]     sel,
    output logic                                 not_ready
);

    localparam int unsigned FWD_SEL_W = fwd_sel_w(NUM_FWD);

    logic [NUM_FWD-1:0] match;

    always_comb begin
        for (int k = 0; k < NUM_FWD; k++) begin
            match[k] = de_ex_valid && src_used && stg_valid[k] && stg_load_regfile[k]
                       && (stg_dr[k] == src);
        end
    end

    // Walk oldest to youngest so the youngest match overwrites.
    always_comb begin
        sel       = '0;
        not_ready = 1'b0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (match[k]) begin
                sel       = FWD_SEL_W'(k + 1);
                not_ready = !stg_ready[k];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, load-use stall/bubble, stall-tracking FSM and hazard counters.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned NUM_FWD   = 2,
    parameter int unsigned STALL_MAX = 32,
    parameter int unsigned CNT_W     = 16
) (
    input logic              clk,
    input logic              rst_n,
    fwd_hazard_unit_if.slave bus
);

    localparam int unsigned FWD_SEL_W = fwd_sel_w(NUM_FWD);
    localparam int unsigned CTR_W     = $clog2(STALL_MAX + 1);

    logic [NUM_SRC-1:0][FWD_SEL_W-1:0] sel;
    logic [NUM_SRC-1:0]                not_ready;
    logic                              stall_raw;

    fwd_hazard_state_t state_q;
    logic [CTR_W-1:0]  stall_ctr_q;
    logic [CNT_W-1:0]  hazard_cnt_q;
    logic [CNT_W-1:0]  stall_cyc_cnt_q;
    logic              timeout_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_match_pri #(
            .NUM_FWD (NUM_FWD)
        ) u_match (
            .de_ex_valid      (bus.de_ex_valid),
            .src              (bus.de_ex_src[i]),
            .src_used         (bus.de_ex_src_used[i]),
            .stg_valid        (bus.stg_valid),
            .stg_load_regfile (bus.stg_load_regfile),
            .stg_dr           (bus.stg_dr),
            .stg_ready        (bus.stg_ready),
            .sel              (sel[i]),
            .not_ready        (not_ready[i])
        );
    end

    assign stall_raw = |not_ready;

    // Outputs are forced quiet for the whole time reset is held, not just after the edge.
    assign bus.fwd_sel       = rst_n ? sel : '0;
    assign bus.stall         = rst_n && stall_raw;
    assign bus.bubble        = rst_n && stall_raw;
    assign bus.stall_timeout = timeout_q;
    assign bus.hazard_cnt    = hazard_cnt_q;
    assign bus.stall_cyc_cnt = stall_cyc_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= FH_RUN;
            stall_ctr_q     <= '0;
            hazard_cnt_q    <= '0;
            stall_cyc_cnt_q <= '0;
            timeout_q       <= 1'b0;
        end else if (!bus.freeze) begin
            if (stall_raw && (stall_cyc_cnt_q != '1)) begin
                stall_cyc_cnt_q <= stall_cyc_cnt_q + 1'b1;
            end
            case (state_q)
                FH_RUN: begin
                    if (stall_raw) begin
                        state_q     <= FH_STALL;
                        stall_ctr_q <= CTR_W'(1);
                        if (hazard_cnt_q != '1) begin
                            hazard_cnt_q <= hazard_cnt_q + 1'b1;
                        end
                        if (STALL_MAX <= 1) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                FH_STALL: begin
                    if (!stall_raw) begin
                        state_q <= FH_RUN;
                    end else if (stall_ctr_q < CTR_W'(STALL_MAX)) begin
                        stall_ctr_q <= stall_ctr_q + 1'b1;
                        if (stall_ctr_q == CTR_W'(STALL_MAX - 1)) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= FH_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed checks of fwd_hazard_unit: a 2-stage/STALL_MAX=4 instance and a 3-stage instance.
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.NUM_SRC(2), .NUM_FWD(2), .CNT_W(16)) bus_a ();
    fwd_hazard_unit_if #(.NUM_SRC(2), .NUM_FWD(3), .CNT_W(16)) bus_b ();

    fwd_hazard_unit #(
        .NUM_SRC   (2),
        .NUM_FWD   (2),
        .STALL_MAX (4),
        .CNT_W     (16)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    fwd_hazard_unit #(
        .NUM_SRC   (2),
        .NUM_FWD   (3),
        .STALL_MAX (32),
        .CNT_W     (16)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus_a.de_ex_valid      = 1'b0;
        bus_a.de_ex_src        = '0;
        bus_a.de_ex_src_used   = '0;
        bus_a.stg_valid        = '0;
        bus_a.stg_load_regfile = '0;
        bus_a.stg_dr           = '0;
        bus_a.stg_ready        = '0;
        bus_a.freeze           = 1'b0;
        bus_b.de_ex_valid      = 1'b0;
        bus_b.de_ex_src        = '0;
        bus_b.de_ex_src_used   = '0;
        bus_b.stg_valid        = '0;
        bus_b.stg_load_regfile = '0;
        bus_b.stg_dr           = '0;
        bus_b.stg_ready        = '0;
        bus_b.freeze           = 1'b0;
    endtask

    // Advance one edge; inputs may be changed right after return.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load to R2 in A's youngest stage, data not yet back.
    task automatic load_use_a(input logic ready);
        bus_a.de_ex_valid         = 1'b1;
        bus_a.de_ex_src[0]        = 3'd2;
        bus_a.de_ex_src_used[0]   = 1'b1;
        bus_a.stg_valid[0]        = 1'b1;
        bus_a.stg_load_regfile[0] = 1'b1;
        bus_a.stg_dr[0]           = 3'd2;
        bus_a.stg_ready[0]        = ready;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        load_use_a(1'b0);
        #2;
        check("rst_gate_stall", 32'(bus_a.stall), 0);
        check("rst_gate_bubble", 32'(bus_a.bubble), 0);
        check("rst_gate_sel", 32'(bus_a.fwd_sel[0]), 0);
        step();
        check("rst_hazard_cnt", 32'(bus_a.hazard_cnt), 0);
        check("rst_cyc_cnt", 32'(bus_a.stall_cyc_cnt), 0);
        check("rst_timeout", 32'(bus_a.stall_timeout), 0);
        clear_inputs();
        rst_n = 1'b1;
        step();

        // Both stages write R3 and are ready: youngest wins, no stall.
        bus_a.de_ex_valid      = 1'b1;
        bus_a.de_ex_src[0]     = 3'd3;
        bus_a.de_ex_src[1]     = 3'd3;
        bus_a.de_ex_src_used   = 2'b01;
        bus_a.stg_valid        = 2'b11;
        bus_a.stg_load_regfile = 2'b11;
        bus_a.stg_dr[0]        = 3'd3;
        bus_a.stg_dr[1]        = 3'd3;
        bus_a.stg_ready        = 2'b11;
        #1;
        check("young_wins_sel0", 32'(bus_a.fwd_sel[0]), 1);
        check("unused_src1_sel", 32'(bus_a.fwd_sel[1]), 0);
        check("young_wins_stall", 32'(bus_a.stall), 0);
        bus_a.stg_load_regfile = 2'b10;
        #1;
        check("old_stage_sel0", 32'(bus_a.fwd_sel[0]), 2);
        bus_a.stg_ready = 2'b01;
        #1;
        check("old_not_ready_stall", 32'(bus_a.stall), 1);

        // Three stages: only stage 2 supplies R5 to src1.
        bus_b.de_ex_valid      = 1'b1;
        bus_b.de_ex_src[1]     = 3'd5;
        bus_b.de_ex_src_used   = 2'b10;
        bus_b.stg_valid        = 3'b101;
        bus_b.stg_load_regfile = 3'b111;
        bus_b.stg_dr[0]        = 3'd4;
        bus_b.stg_dr[1]        = 3'd5;
        bus_b.stg_dr[2]        = 3'd5;
        bus_b.stg_ready        = 3'b111;
        #1;
        check("b_stage2_sel1", 32'(bus_b.fwd_sel[1]), 3);
        bus_b.de_ex_src_used = 2'b00;
        #1;
        check("b_unused_sel1", 32'(bus_b.fwd_sel[1]), 0);
        bus_b.de_ex_src_used = 2'b10;
        bus_b.de_ex_valid    = 1'b0;
        #1;
        check("b_invalid_sel1", 32'(bus_b.fwd_sel[1]), 0);
        // Ready younger match hides a not-ready older one.
        bus_b.de_ex_valid = 1'b1;
        bus_b.stg_dr[0]   = 3'd5;
        bus_b.stg_ready   = 3'b011;
        #1;
        check("b_young_ready_sel1", 32'(bus_b.fwd_sel[1]), 1);
        check("b_young_ready_stall", 32'(bus_b.stall), 0);

        // Three-cycle load-use stall.
        clear_inputs();
        load_use_a(1'b0);
        #1;
        check("lu_sel0", 32'(bus_a.fwd_sel[0]), 1);
        for (int c = 0; c < 3; c++) begin
            check("lu_stall", 32'(bus_a.stall), 1);
            check("lu_bubble", 32'(bus_a.bubble), 1);
            step();
        end
        bus_a.stg_ready[0] = 1'b1;
        #1;
        check("lu_clear_stall", 32'(bus_a.stall), 0);
        check("lu_hazard_cnt", 32'(bus_a.hazard_cnt), 1);
        check("lu_cyc_cnt", 32'(bus_a.stall_cyc_cnt), 3);
        check("lu_no_timeout", 32'(bus_a.stall_timeout), 0);
        step();

        // New stall, frozen for 4 edges after its first cycle.
        bus_a.stg_ready[0] = 1'b0;
        step();
        check("fz_entry_hazard", 32'(bus_a.hazard_cnt), 2);
        check("fz_entry_cyc", 32'(bus_a.stall_cyc_cnt), 4);
        bus_a.freeze = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("fz_stall_comb", 32'(bus_a.stall), 1);
            step();
            check("fz_hold_hazard", 32'(bus_a.hazard_cnt), 2);
            check("fz_hold_cyc", 32'(bus_a.stall_cyc_cnt), 4);
            check("fz_hold_timeout", 32'(bus_a.stall_timeout), 0);
        end
        bus_a.freeze = 1'b0;
        step();
        step();
        check("to_before_max", 32'(bus_a.stall_timeout), 0);
        step();
        check("to_at_max", 32'(bus_a.stall_timeout), 1);
        check("to_cyc", 32'(bus_a.stall_cyc_cnt), 7);
        bus_a.stg_ready[0] = 1'b1;
        step();
        check("to_sticky", 32'(bus_a.stall_timeout), 1);

        // Hazard straight after the stall clears is a fresh event.
        bus_a.stg_ready[0] = 1'b0;
        step();
        check("reentry_hazard", 32'(bus_a.hazard_cnt), 3);
        check("reentry_cyc", 32'(bus_a.stall_cyc_cnt), 8);

        // Reset while stalled.
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall", 32'(bus_a.stall), 0);
        check("rst_mid_sel", 32'(bus_a.fwd_sel[0]), 0);
        step();
        check("rst_mid_hazard", 32'(bus_a.hazard_cnt), 0);
        check("rst_mid_cyc", 32'(bus_a.stall_cyc_cnt), 0);
        check("rst_mid_timeout", 32'(bus_a.stall_timeout), 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_stall", 32'(bus_a.stall), 1);
        step();
        check("post_rst_run_entry", 32'(bus_a.hazard_cnt), 1);
        check("post_rst_cyc", 32'(bus_a.stall_cyc_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
